bot_loc_sync: RTL and testbench
===============================

Name: bot_loc_sync

Overview:
- Sits between the RojoBot world-simulator/CPU register interface and the icon overlay stage.
- Captures bot location and status updates into a shadow set, then commits them to the display-facing LocX_reg/LocY_reg/BotInfo_reg only during vertical blanking, so the icon never tears mid-frame.
- Also generates the CPU update flag IO_BotUpdt_Sync (set on update, cleared on acknowledge) and counts overruns, where an update arrives before the previous one was committed.

Parameters:
- RESET_LOCX, 8'd64, display and shadow LocX value after reset
- RESET_LOCY, 8'd64, display and shadow LocY value after reset
- RESET_INFO, 8'd0, display and shadow BotInfo value after reset
- OVR_W, 8, width of the saturating overrun counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- LocX_in  in  8  new bot X location from simulator
- LocY_in  in  8  new bot Y location from simulator
- BotInfo_in  in  8  new bot orientation/status from simulator
- upd_sysregs  in  1  one-cycle strobe: *_in valid this cycle
- video_vblank  in  1  level from display timing generator: 1 during vertical blanking
- IO_INT_ACK  in  1  one-cycle CPU acknowledge of update flag
- LocX_reg  out  8  frame-stable X location to icon stage
- LocY_reg  out  8  frame-stable Y location to icon stage
- BotInfo_reg  out  8  frame-stable BotInfo to icon stage
- IO_BotUpdt_Sync  out  1  update flag to CPU
- commit_stb  out  1  one-cycle pulse when display registers were loaded
- pending  out  1  shadow holds an uncommitted update
- overrun_cnt  out  OVR_W  saturating count of overwritten, never-committed updates

Behaviour:
- Reset (resetn=0, asynchronous):
  - LocX_reg and shadow X = RESET_LOCX; LocY_reg and shadow Y = RESET_LOCY; BotInfo_reg and shadow info = RESET_INFO.
  - IO_BotUpdt_Sync=0, commit_stb=0, pending=0, overrun_cnt=0, state=IDLE.
  - Reset mid-operation discards any pending update.
- Capture: on any edge with upd_sysregs=1, the shadow registers load *_in, and pending=1 after that edge.
- State machine: IDLE (pending=0), PEND (pending=1, waiting for blanking).
  - IDLE -> PEND when upd_sysregs=1.
  - PEND -> IDLE when video_vblank=1 and upd_sysregs=0; this is a commit.
  - PEND with video_vblank=1 and upd_sysregs=1: commit the old shadow contents, capture the new values into the shadow, stay in PEND (pending stays 1).
  - PEND with video_vblank=0: hold.
  - IDLE with upd_sysregs=1 and video_vblank=1: goes to PEND only. No same-cycle commit; commit occurs on the next edge if vblank is still 1.
- Commit: display registers load the shadow contents (value before this edge). commit_stb=1 for exactly the cycle after a commit edge, otherwise 0.
- Latency: strobe at edge N with vblank held high gives display registers updated at edge N+1 and commit_stb high during cycle N+1.
- Display registers never change while video_vblank=0.
- Update flag:
  - IO_BotUpdt_Sync is set at the edge where upd_sysregs=1.
  - It is cleared at the edge where IO_INT_ACK=1.
  - If both occur on the same edge, set wins (flag stays 1).
  - ACK while flag=0 has no effect.
- Overrun: at an edge with upd_sysregs=1 while pending=1 and no commit on that edge, overrun_cnt increments.
  - Saturates at 2^OVR_W-1; no wrap.
  - Cleared only by reset.
  - The newest data always wins in the shadow.
- video_vblank is assumed synchronous to clk (the timing generator shares the clock); no synchronizer inside.

Test Plan:
- Reset: assert resetn=0 mid-run with pending=1 -> outputs immediately 64/64/0, flag=0, pending=0, overrun_cnt=0; after release, no commit occurs on the next vblank.
- Basic commit: vblank=0, strobe X=10,Y=20,Info=3 -> display regs remain 64/64/0 for 100 cycles, pending=1, flag=1; raise vblank -> regs=10/20/3 on the next edge, commit_stb high for exactly 1 cycle, pending=0.
- Overrun: vblank=0, strobes X=1 then X=2 then X=3 -> overrun_cnt=2; vblank=1 -> LocX_reg=3; 300 strobes without vblank -> overrun_cnt=255 and holds.
- Commit+capture collision: pending with X=5, vblank=1 and strobe X=6 on the same edge -> LocX_reg=5, pending stays 1, overrun_cnt unchanged; next edge LocX_reg=6, pending=0.
- Flag handshake: strobe then IO_INT_ACK 3 cycles later -> flag 1 for 3 cycles then 0; strobe and ACK on the same edge -> flag=1; ACK with flag=0 -> stays 0.
- Idle-in-vblank: vblank=1 constantly, strobe X=9 at edge N -> LocX_reg=9 at edge N+1, not at edge N.

Source files
------------

// File: rtl/bot_loc_sync.sv
// bot_loc_sync: shadows RojoBot location/status and commits it to the icon stage only during vblank.
module bot_loc_sync #(
  parameter logic [7:0] RESET_LOCX = 8'd64,
  parameter logic [7:0] RESET_LOCY = 8'd64,
  parameter logic [7:0] RESET_INFO = 8'd0,
  parameter int         OVR_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       LocX_in,
  input  logic [7:0]       LocY_in,
  input  logic [7:0]       BotInfo_in,
  input  logic             upd_sysregs,
  input  logic             video_vblank,
  input  logic             IO_INT_ACK,
  output logic [7:0]       LocX_reg,
  output logic [7:0]       LocY_reg,
  output logic [7:0]       BotInfo_reg,
  output logic             IO_BotUpdt_Sync,
  output logic             commit_stb,
  output logic             pending,
  output logic [OVR_W-1:0] overrun_cnt
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t r_state, w_next;
  logic [7:0] r_sx, r_sy, r_si;
  logic w_commit;
  assign pending  = (r_state == PEND);
  assign w_commit = pending && video_vblank;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  // A strobe arriving in the commit cycle refills the shadow, so we stay in PEND.
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (upd_sysregs ? PEND : IDLE)
                               : ((video_vblank && !upd_sysregs) ? IDLE : PEND);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sx            <= RESET_LOCX;
      r_sy            <= RESET_LOCY;
      r_si            <= RESET_INFO;
      LocX_reg        <= RESET_LOCX;
      LocY_reg        <= RESET_LOCY;
      BotInfo_reg     <= RESET_INFO;
      IO_BotUpdt_Sync <= 1'b0;
      commit_stb      <= 1'b0;
      overrun_cnt     <= '0;
    end else begin
      commit_stb <= w_commit;
      if (w_commit) begin
        LocX_reg    <= r_sx;
        LocY_reg    <= r_sy;
        BotInfo_reg <= r_si;
      end
      if (upd_sysregs) begin
        r_sx <= LocX_in;
        r_sy <= LocY_in;
        r_si <= BotInfo_in;
      end
      if (upd_sysregs && pending && !w_commit && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + 1'b1;
      IO_BotUpdt_Sync <= upd_sysregs | (IO_BotUpdt_Sync & ~IO_INT_ACK);
    end
  end
endmodule

// File: tb/tb_bot_loc_sync.sv
// tb_bot_loc_sync: vector table, directed corner sequences and randomized run against a rule-level model.
module tb_bot_loc_sync;
  localparam int W = 8;
  localparam int OMAX = (1 << W) - 1;
  logic clk = 0, resetn = 0, upd = 0, vb = 0, ack = 0;
  logic [7:0] xin = 0, yin = 0, iin = 0;
  logic [7:0] lx, ly, li;
  logic flag, cstb, pend;
  logic [W-1:0] ovr;
  int checks = 0, errors = 0;
  int m_sx, m_sy, m_si, m_dx, m_dy, m_di, m_ovr;
  bit m_pend, m_flag, m_cstb;

  bot_loc_sync #(.OVR_W(W)) dut (
    .clk(clk), .resetn(resetn), .LocX_in(xin), .LocY_in(yin), .BotInfo_in(iin),
    .upd_sysregs(upd), .video_vblank(vb), .IO_INT_ACK(ack),
    .LocX_reg(lx), .LocY_reg(ly), .BotInfo_reg(li), .IO_BotUpdt_Sync(flag),
    .commit_stb(cstb), .pending(pend), .overrun_cnt(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic u, v, a;
    logic [7:0] x, y, i, ex, ey, ei;
    logic ep, ef, ec;
    int eo;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 64; m_sy = 64; m_si = 0; m_dx = 64; m_dy = 64; m_di = 0;
    m_ovr = 0; m_pend = 0; m_flag = 0; m_cstb = 0;
  endtask

  // Applies inputs across one rising edge, advances the model, and returns 1ns after the edge.
  task automatic cyc(input logic u, v, a, input logic [7:0] x, y, i);
    bit c;
    upd = u; vb = v; ack = a; xin = x; yin = y; iin = i;
    @(posedge clk); #1;
    c = m_pend && v;
    m_cstb = c;
    if (c) begin m_dx = m_sx; m_dy = m_sy; m_di = m_si; end
    if (u && m_pend && !c && m_ovr < OMAX) m_ovr++;
    m_pend = u | (m_pend & !c);
    if (u) begin m_sx = x; m_sy = y; m_si = i; end
    m_flag = u | (m_flag & !a);
  endtask

  task automatic do_reset();
    upd = 0; vb = 0; ack = 0;
    @(negedge clk); resetn = 0; #2; resetn = 1;
    model_reset();
  endtask

  task automatic chk_model(input string n);
    chk({n, "_x"}, lx, m_dx);
    chk({n, "_y"}, ly, m_dy);
    chk({n, "_info"}, li, m_di);
    chk({n, "_pend"}, pend, m_pend);
    chk({n, "_flag"}, flag, m_flag);
    chk({n, "_cstb"}, cstb, m_cstb);
    chk({n, "_ovr"}, ovr, m_ovr);
  endtask

  initial begin
    tbl[0]  = '{1,0,0, 10,20,3,  64,64,0, 1,1,0, 0};
    tbl[1]  = '{0,0,0, 0,0,0,    64,64,0, 1,1,0, 0};
    tbl[2]  = '{0,1,0, 0,0,0,    10,20,3, 0,1,1, 0};
    tbl[3]  = '{0,1,1, 0,0,0,    10,20,3, 0,0,0, 0};
    tbl[4]  = '{1,0,0, 1,11,1,   10,20,3, 1,1,0, 0};
    tbl[5]  = '{1,0,0, 2,12,2,   10,20,3, 1,1,0, 1};
    tbl[6]  = '{1,0,1, 3,13,7,   10,20,3, 1,1,0, 2};
    tbl[7]  = '{0,1,0, 0,0,0,    3,13,7,  0,1,1, 2};
    tbl[8]  = '{1,1,0, 5,50,5,   3,13,7,  1,1,0, 2};
    tbl[9]  = '{1,1,0, 6,60,6,   5,50,5,  1,1,1, 2};
    tbl[10] = '{0,1,0, 0,0,0,    6,60,6,  0,1,1, 2};
    tbl[11] = '{0,0,1, 0,0,0,    6,60,6,  0,0,0, 2};
    tbl[12] = '{0,0,1, 0,0,0,    6,60,6,  0,0,0, 2};
    model_reset();
    #12 resetn = 1;
    @(negedge clk);
    chk("rst_x", lx, 64); chk("rst_y", ly, 64); chk("rst_info", li, 0);
    chk("rst_flag", flag, 0); chk("rst_pend", pend, 0); chk("rst_ovr", ovr, 0);
    chk("rst_cstb", cstb, 0);

    for (int k = 0; k < 13; k++) begin
      cyc(tbl[k].u, tbl[k].v, tbl[k].a, tbl[k].x, tbl[k].y, tbl[k].i);
      chk($sformatf("tbl%0d_x", k), lx, tbl[k].ex);
      chk($sformatf("tbl%0d_y", k), ly, tbl[k].ey);
      chk($sformatf("tbl%0d_info", k), li, tbl[k].ei);
      chk($sformatf("tbl%0d_pend", k), pend, tbl[k].ep);
      chk($sformatf("tbl%0d_flag", k), flag, tbl[k].ef);
      chk($sformatf("tbl%0d_cstb", k), cstb, tbl[k].ec);
      chk($sformatf("tbl%0d_ovr", k), ovr, tbl[k].eo);
    end

    do_reset();
    cyc(1, 0, 0, 10, 20, 3);
    for (int k = 0; k < 100; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("hold_x", lx, 64);
    end
    chk("hold_pend", pend, 1); chk("hold_flag", flag, 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("bc_x", lx, 10); chk("bc_y", ly, 20); chk("bc_info", li, 3);
    chk("bc_cstb", cstb, 1); chk("bc_pend", pend, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("bc_cstb_once", cstb, 0);

    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 299; k++) cyc(1, 0, 0, 8'(k), 0, 0);
    chk("sat_ovr", ovr, 255);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat_hold", ovr, 255);

    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("flg_c1", flag, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("flg_c2", flag, 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("flg_clr", flag, 0);

    cyc(1, 0, 0, 33, 44, 55);
    cyc(1, 0, 0, 34, 45, 56);
    upd = 0;
    resetn = 0; #1;
    chk("arst_x", lx, 64); chk("arst_y", ly, 64); chk("arst_info", li, 0);
    chk("arst_flag", flag, 0); chk("arst_pend", pend, 0); chk("arst_ovr", ovr, 0);
    #2 resetn = 1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("arst_nocommit_cstb", cstb, 0);
      chk("arst_nocommit_x", lx, 64);
    end

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          8'($urandom), 8'($urandom), 8'($urandom));
      chk_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
